ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter and sequencer for the 1024 x 8 on-chip RAM. Requester A (e.g. a host/config port) and requester B (e.g. a streaming datapath) each issue single-beat read or write commands. The block grants at most one command per cycle to the single physical RAM port, using round-robin with a bounded burst length, and routes registered read data back to the requester that issued the read. It sits between the requesters and the memory array, which it instantiates.

## Interface
Parameters:
- ADDR_W, 10: address width; memory depth = 2**ADDR_W.
- DATA_W, 8: data width.
- BURST_MAX, 4: maximum consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports (X = a or b; one set per requester):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_X  in  1  command valid; must stay high with its command stable until gnt_X.
- we_X  in  1  1 = write, 0 = read.
- addr_X  in  ADDR_W  word address.
- wdata_X  in  DATA_W  write data.
- gnt_X  out  1  command accepted this cycle; combinational from state and req inputs.
- rvalid_X  out  1  one-cycle pulse; rdata_X holds valid read data.
- rdata_X  out  DATA_W  read data; holds its last value when rvalid_X = 0.

## Operation
- States: IDLE, OWN_A, OWN_B. A 4-bit burst counter cnt counts consecutive grants to the current owner. A last-served bit last selects the round-robin winner.
- The owner for the current cycle is computed combinationally:
  - IDLE: if only one requester is active, grant it. If both are active, grant the one that is not last.
  - OWN_X: keep X if req_X is high and either cnt < BURST_MAX or the other requester is idle. Otherwise grant the other requester if it is requesting. Otherwise no grant.
- gnt_a and gnt_b are never high together. No grant is issued without the corresponding req.
- At each edge:
  - state <= owner (IDLE if no grant).
  - cnt <= cnt+1 (saturating at BURST_MAX) when the owner is unchanged, 1 on a change of owner, 0 on IDLE.
  - last <= the granted requester.
- Granted write: mem[addr] <= wdata at that edge.
- Granted read: the RAM output is registered, so rdata_X and rvalid_X appear on the next cycle.
- Read-during-write to the same address cannot occur, because there is only one access per cycle.
- A read issued the cycle after a write to the same address returns the new data.
- Addresses are always in range; there is no wrap or overflow handling.
- A req that is deasserted before gnt is treated as withdrawn. This is legal and has no side effect.

## Timing
- Reset (async assert, synchronous deassert is expected upstream):
  - state = IDLE, cnt = 0, last = B (so A wins the first tie).
  - rvalid_a = rvalid_b = 0, rdata_a = rdata_b = 0.
  - gnt_X follows the reset-state rule from the first cycle after release.
- Memory contents are not reset and are undefined until written.
- Grant latency: 0 cycles (same cycle as req) when uncontended.
- Read latency: rvalid exactly 1 cycle after gnt.
- Write latency: data is visible to a read granted on the following cycle.
- Throughput: 1 command per cycle aggregate.
- Under continuous contention each requester waits at most BURST_MAX cycles between grants.
- If reset asserts with a read in flight, that read's rvalid is suppressed. An in-flight write is either completed or dropped, and is not retried.

## Structure
- Shared package ram_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state encoding typedef (IDLE/OWN_A/OWN_B);
  - the requester id constants REQ_A = 0 and REQ_B = 1.
- Sub-module ram_sp_sync: a single-port synchronous RAM (DEPTH x DATA_W) with we, addr, wdata, and a registered rdata. It has no reset on the array.
- A one-bit read-tag register records which requester issued the read, and steers rdata/rvalid.

## Test plan
- Reset, then A writes 0x5A to addr 0x003 and reads it the next cycle -> gnt_a the same cycle as each req; rvalid_a=1 and rdata_a=0x5A one cycle after the read grant; B outputs stay 0.
- Both requesters assert req in the first cycle after reset -> A granted first (last=B), then B; with continuous reqs and BURST_MAX=4, the grant pattern is AAAA BBBB AAAA.
- Only B requests for 10 consecutive reads -> gnt_b on all 10 cycles; the burst limit does not block a lone requester.
- Interleaved: A writes 0x11 to 0x3FF while B reads 0x3FF in a contended cycle -> A granted first, and B's later read returns 0x11 on rdata_b with rvalid_a=0.
- B drops req after 1 wait cycle while A holds the port -> B never receives gnt_b, and no rvalid_b is produced.
- rst_n pulsed low for a partial cycle right after a read grant -> rvalid is not asserted; state is IDLE, cnt=0, and A wins the next tie.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM arbiter slice: state encoding,
// requester ids and default bus widths.
package ram_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with a registered read port.
// A write cycle also returns the old contents on rdata; callers ignore it.
module ram_sp_sync #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its output register are deliberately left without reset
  // so the RAM maps onto a plain block memory.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts in front of a
// single-port RAM; read data is steered back by a one-bit read tag.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              last, last_nxt;
  logic              rd_pend, rd_tag;
  logic [DATA_W-1:0] hold_a, hold_b;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) begin
          gnt_a = (last == REQ_B);
          gnt_b = (last == REQ_A);
        end else begin
          gnt_a = req_a;
          gnt_b = req_b;
        end
      end
      OWN_A: begin
        if (req_a && (cnt < BMAX || !req_b)) gnt_a = 1'b1;
        else if (req_b)                      gnt_b = 1'b1;
      end
      OWN_B: begin
        if (req_b && (cnt < BMAX || !req_a)) gnt_b = 1'b1;
        else if (req_a)                      gnt_a = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    if (gnt_a) begin
      state_nxt = OWN_A;
      last_nxt  = REQ_A;
    end else if (gnt_b) begin
      state_nxt = OWN_B;
      last_nxt  = REQ_B;
    end

    cnt_nxt = 4'd0;
    if (state_nxt != IDLE) begin
      if (state_nxt == state) cnt_nxt = (cnt < BMAX) ? cnt + 4'd1 : cnt;
      else                    cnt_nxt = 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= REQ_B;
      rd_pend <= 1'b0;
      rd_tag  <= REQ_A;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      rd_pend <= (gnt_a && !we_a) || (gnt_b && !we_b);
      rd_tag  <= gnt_b ? REQ_B : REQ_A;
    end
  end

  assign ram_we    = (gnt_a && we_a) || (gnt_b && we_b);
  assign ram_addr  = gnt_b ? addr_b  : addr_a;
  assign ram_wdata = gnt_b ? wdata_b : wdata_a;

  ram_sp_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign rvalid_a = rd_pend && (rd_tag == REQ_A);
  assign rvalid_b = rd_pend && (rd_tag == REQ_B);

  // The RAM output register is shared, so each side keeps its own copy of
  // the last word it received to hold rdata between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      if (rvalid_a) hold_a <= ram_q;
      if (rvalid_b) hold_b <= ram_q;
    end
  end

  assign rdata_a = rvalid_a ? ram_q : hold_a;
  assign rdata_b = rvalid_b ? ram_q : hold_b;

endmodule
